// File: rtl/regfile_write_arbiter_pkg.sv
// Shared state encoding and default bank dimensions for the register-bank write arbiter.
package rf_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    localparam int DEF_BUS_WIDTH = 8;
    localparam int DEF_NUM_REGS  = 8;
    localparam int DEF_NUM_REQ   = 3;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_picker.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping to 0.
module rr_priority_picker
    import rf_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   win_idx,
    output logic               valid
);

    always_comb begin
        int cand;
        cand    = 0;
        winner  = '0;
        win_idx = '0;
        valid   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port; every output is registered.
// Build option RF_ARB_ZERO_REG_EN: register 0 is hard-wired zero (granted, but no write strobe).
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter  int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter  int NUM_REGS   = DEF_NUM_REGS,
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          write_control,
    output logic [NUM_REGS-1:0]           wr_sel,
    output logic [BUS_WIDTH-1:0]          wr_data,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t                r_state, w_state_nxt;
    logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]      r_win, w_win_nxt;
    logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
    logic                  r_wc, w_wc_nxt;
    logic [NUM_REGS-1:0]   r_sel, w_sel_nxt;
    logic [BUS_WIDTH-1:0]  r_data, w_data_nxt;
    logic                  r_busy, w_busy_nxt;

    logic [NUM_REQ-1:0]    w_pick_onehot;
    logic [PTR_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;
    logic [ADDR_WIDTH-1:0] w_addr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req),
        .ptr     (r_ptr),
        .winner  (w_pick_onehot),
        .win_idx (w_pick_idx),
        .valid   (w_pick_valid)
    );

    assign w_addr = req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_grant <= '0;
            r_wc    <= 1'b0;
            r_sel   <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_grant <= w_grant_nxt;
            r_wc    <= w_wc_nxt;
            r_sel   <= w_sel_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Every output defaults to 0 so the WRITE strobe can only ever last one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_grant_nxt = '0;
        w_wc_nxt    = 1'b0;
        w_sel_nxt   = '0;
        w_data_nxt  = '0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_WRITE;
                    w_win_nxt   = w_pick_idx;
                    w_grant_nxt = w_pick_onehot;
                    w_wc_nxt    = 1'b1;
                    w_data_nxt  = req_data[int'(w_pick_idx)*BUS_WIDTH +: BUS_WIDTH];
                    w_busy_nxt  = 1'b1;
                    // Out-of-range addresses match no bit, so the write is silently dropped.
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (w_addr == ADDR_WIDTH'(k)) w_sel_nxt[k] = 1'b1;
                    end
`ifdef RF_ARB_ZERO_REG_EN
                    if (w_addr == '0) begin
                        w_sel_nxt = '0;
                        w_wc_nxt  = 1'b0;
                    end
`endif
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = PTR_W'(wrap_inc(int'(r_win), NUM_REQ));
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign grant         = r_grant;
    assign write_control = r_wc;
    assign wr_sel        = r_sel;
    assign wr_data       = r_data;
    assign busy          = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle model comparison plus directed literal checks.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int NR = 8;
    localparam int BW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*AW-1:0] req_addr;
    logic [N*BW-1:0] req_data;
    logic [N-1:0]  grant;
    logic          write_control;
    logic [NR-1:0] wr_sel;
    logic [BW-1:0] wr_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.BUS_WIDTH(BW), .NUM_REGS(NR), .NUM_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .grant         (grant),
        .write_control (write_control),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .busy          (busy)
    );

    // Register bank: captures on the falling edge inside WRITE; reset dominates.
    logic [BW-1:0] bank [NR];
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < NR; k++) bank[k] <= '0;
        end else if (write_control) begin
            for (int k = 0; k < NR; k++) if (wr_sel[k]) bank[k] <= wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one write slot per two cycles, round-robin from the slot after the last winner.
    bit            m_write = 1'b0;
    int            m_ptr = 0;
    int            m_w = 0;
    int            m_a;
    logic [N-1:0]  e_grant = '0;
    logic          e_wc = 1'b0;
    logic [NR-1:0] e_sel = '0;
    logic [BW-1:0] e_data = '0;
    logic          e_busy = 1'b0;

    always @(posedge clk) begin
        e_grant = '0; e_wc = 1'b0; e_sel = '0; e_data = '0; e_busy = 1'b0;
        if (rst) begin
            m_write = 1'b0;
            m_ptr   = 0;
        end else if (m_write) begin
            m_write = 1'b0;
            m_ptr   = (m_w + 1) % N;
        end else if (req != '0) begin
            m_w = -1;
            for (int k = 0; k < N; k++)
                if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            m_a     = int'(req_addr[m_w*AW +: AW]);
            e_grant = N'(1) << m_w;
            e_wc    = 1'b1;
            e_sel   = (m_a < NR) ? (NR'(1) << m_a) : '0;
            e_data  = req_data[m_w*BW +: BW];
            e_busy  = 1'b1;
`ifdef RF_ARB_ZERO_REG_EN
            if (m_a == 0) begin e_sel = '0; e_wc = 1'b0; end
`endif
            m_write = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("grant", 32'(grant), 32'(e_grant));
        check("write_control", 32'(write_control), 32'(e_wc));
        check("wr_sel", 32'(wr_sel), 32'(e_sel));
        check("wr_data", 32'(wr_data), 32'(e_data));
        check("busy", 32'(busy), 32'(e_busy));
        check("sel_onehot", 32'($countones(wr_sel) <= 1), 32'(1));
        check("sel_without_wc", 32'(!write_control && wr_sel != '0), 32'(0));
    end

    logic [N-1:0] hold = '0;
    logic [N-1:0] pend = '0;

    // Advance one clock; requesters drop on grant and, if holding, re-raise one cycle later.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin req[i] = 1'b1; pend[i] = 1'b0; end
            if (grant[i]) begin req[i] = 1'b0; if (hold[i]) pend[i] = 1'b1; end
        end
    endtask

    task automatic set_rq(input int i, input logic [AW-1:0] a, input logic [BW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*BW +: BW] = d;
    endtask

    logic [N-1:0] glog [12];
    logic [N-1:0] gexp [12];

    initial begin
        rst = 1'b1;
        req = 3'b111;
        req_addr = '0;
        req_data = '0;
        set_rq(0, 3'd1, 8'h11);
        set_rq(1, 3'd2, 8'h22);
        set_rq(2, 3'd4, 8'h44);

        // Reset held with all requests pending
        step(); step();
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_wr_sel", 32'(wr_sel), 32'(0));
        rst = 1'b0;
        step();
        check("first_grant", 32'(grant), 32'(3'b001));
        check("first_data", 32'(wr_data), 32'(8'h11));
        req = '0;
        step(); step();

        // Single request to register 5
        set_rq(1, 3'd5, 8'hA5);
        req = 3'b010;
        step();
        check("single_grant", 32'(grant), 32'(3'b010));
        check("single_sel", 32'(wr_sel), 32'(8'b0010_0000));
        check("single_data", 32'(wr_data), 32'(8'hA5));
        check("single_wc", 32'(write_control), 32'(1));
        step();
        check("single_grant_drop", 32'(grant), 32'(0));
        check("single_wc_drop", 32'(write_control), 32'(0));
        check("reg5", 32'(bank[5]), 32'(8'hA5));

        // Fairness from ptr=0 with all three requesters holding
        rst = 1'b1; step(); rst = 1'b0;
        gexp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        hold = 3'b111;
        req  = 3'b111;
        for (int k = 0; k < 12; k++) begin
            step();
            glog[k] = grant;
        end
        hold = '0; pend = '0; req = '0;
        for (int k = 0; k < 12; k++) check($sformatf("fair_%0d", k), 32'(glog[k]), 32'(gexp[k]));
        step();

        // Wrap: move ptr to 2, then requests 0 and 1
        req = 3'b010;
        step(); step();
        req = 3'b011;
        step();
        check("wrap_first", 32'(grant), 32'(3'b001));
        step(); step();
        check("wrap_second", 32'(grant), 32'(3'b010));
        step();
        req = 3'b111;
        step();
        check("wrap_ptr2", 32'(grant), 32'(3'b100));
        req = '0;
        step();

        // Reset during WRITE to register 3
        set_rq(1, 3'd3, 8'h3C);
        set_rq(2, 3'd6, 8'h66);
        req = 3'b010;
        step();
        check("mid_grant", 32'(grant), 32'(3'b010));
        rst = 1'b1;
        req = 3'b110;
        step();
        check("mid_reg3", 32'(bank[3]), 32'(8'h00));
        check("mid_busy", 32'(busy), 32'(0));
        check("mid_grant_clr", 32'(grant), 32'(0));
        rst = 1'b0;
        step();
        check("mid_regrant", 32'(grant), 32'(3'b010));
        check("mid_regrant_sel", 32'(wr_sel), 32'(8'b0000_1000));
        step(); step();
        check("mid_next", 32'(grant), 32'(3'b100));
        step();
        check("mid_reg3_final", 32'(bank[3]), 32'(8'h3C));
        check("mid_reg6_final", 32'(bank[6]), 32'(8'h66));

        // Write of 8'hFF to register 0
        set_rq(0, 3'd0, 8'hFF);
        req = 3'b001;
        step();
        check("zero_grant", 32'(grant), 32'(3'b001));
`ifdef RF_ARB_ZERO_REG_EN
        check("zero_wc", 32'(write_control), 32'(0));
        check("zero_sel", 32'(wr_sel), 32'(0));
        step();
        check("zero_reg0", 32'(bank[0]), 32'(8'h00));
`else
        check("zero_wc", 32'(write_control), 32'(1));
        check("zero_sel", 32'(wr_sel), 32'(8'b0000_0001));
        step();
        check("zero_reg0", 32'(bank[0]), 32'(8'hFF));
`endif
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
